// File: rtl/gfx_rom_fetch.sv
// GFX ROM tile-row fetcher: 2-entry request FIFO feeding a fixed-latency ROM access.
// Optional horizontal flip of fetched pixels is enabled with `define GFX_FETCH_FLIPX_EN.
module gfx_rom_fetch #(
    parameter int ROM_WAIT = 8
) (
    input  logic        M24,
    input  logic        RES,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [15:0] REQ_CODE,
    input  logic [2:0]  REQ_ROW,
    input  logic        REQ_FLIPX,
    output logic [18:0] ADDR,
    output logic        CEn,
    output logic        H18,
    output logic        H18n,
    input  logic [31:0] ROM_DATA,
    output logic [31:0] VC,
    output logic        VC_VALID,
    output logic        BUSY
);

`ifdef GFX_FETCH_FLIPX_EN
    localparam int EW = 20;
`else
    localparam int EW = 19;
`endif

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [EW-1:0] fifo [2];
    logic [EW-1:0] entry;
    logic [EW-1:0] head;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          push;
    logic          pop;
    logic          done;
    logic [3:0]    cnt;
    logic [31:0]   vc_next;

    assign REQ_READY = (count < 2'd2);
    assign push      = REQ_VALID && REQ_READY;
    assign head      = fifo[rd_ptr];
    assign H18       = ADDR[18];
    assign H18n      = ~ADDR[18];
    assign BUSY      = (state == FETCH);

`ifdef GFX_FETCH_FLIPX_EN
    logic flip_cur;

    assign entry = {REQ_FLIPX, REQ_CODE, REQ_ROW};

    // Mirror pixel order within each plane byte.
    always_comb begin
        vc_next = ROM_DATA;
        if (flip_cur) begin
            for (int b = 0; b < 4; b++) begin
                for (int p = 0; p < 8; p++) begin
                    vc_next[b*8+p] = ROM_DATA[b*8+7-p];
                end
            end
        end
    end

    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            flip_cur <= 1'b0;
        end else if (pop) begin
            flip_cur <= head[19];
        end
    end
`else
    logic unused_flipx;

    assign unused_flipx = REQ_FLIPX;
    assign entry        = {REQ_CODE, REQ_ROW};
    assign vc_next      = ROM_DATA;
`endif

    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    pop       = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (cnt == 4'd0) begin
                    done = 1'b1;
                    if (count != 2'd0) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge M24) begin
        if (push) begin
            fifo[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            ADDR     <= 19'd0;
            CEn      <= 1'b1;
            cnt      <= 4'd0;
            VC       <= 32'd0;
            VC_VALID <= 1'b0;
        end else begin
            VC_VALID <= done;
            if (done) begin
                VC <= vc_next;
            end
            if (pop) begin
                ADDR <= head[18:0];
                CEn  <= 1'b0;
                cnt  <= 4'(ROM_WAIT - 1);
            end else if (done) begin
                CEn <= 1'b1;
            end else if (state == FETCH) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_gfx_rom_fetch.sv
// Scoreboard bench for gfx_rom_fetch: directed requests, queued expected VC words.
// Second instance runs at the minimum ROM_WAIT of 2.
module tb_gfx_rom_fetch;

    logic        M24 = 1'b0;
    logic        RES = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [15:0] REQ_CODE = '0;
    logic [2:0]  REQ_ROW = '0;
    logic        REQ_FLIPX = 1'b0;
    logic [18:0] ADDR;
    logic        CEn;
    logic        H18;
    logic        H18n;
    logic [31:0] ROM_DATA;
    logic [31:0] VC;
    logic        VC_VALID;
    logic        BUSY;

    logic        REQ_VALID2 = 1'b0;
    logic        REQ_READY2;
    logic [15:0] REQ_CODE2 = '0;
    logic [2:0]  REQ_ROW2 = '0;
    logic        REQ_FLIPX2 = 1'b0;
    logic [18:0] ADDR2;
    logic        CEn2;
    logic        H18_2;
    logic        H18n2;
    logic [31:0] ROM_DATA2;
    logic [31:0] VC2;
    logic        VC_VALID2;
    logic        BUSY2;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb [$];
    logic [31:0] sb2 [$];

    always #5 M24 = ~M24;

    gfx_rom_fetch #(.ROM_WAIT(8)) dut (
        .M24(M24), .RES(RES), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_CODE(REQ_CODE), .REQ_ROW(REQ_ROW), .REQ_FLIPX(REQ_FLIPX),
        .ADDR(ADDR), .CEn(CEn), .H18(H18), .H18n(H18n), .ROM_DATA(ROM_DATA),
        .VC(VC), .VC_VALID(VC_VALID), .BUSY(BUSY)
    );

    gfx_rom_fetch #(.ROM_WAIT(2)) dut2 (
        .M24(M24), .RES(RES), .REQ_VALID(REQ_VALID2), .REQ_READY(REQ_READY2),
        .REQ_CODE(REQ_CODE2), .REQ_ROW(REQ_ROW2), .REQ_FLIPX(REQ_FLIPX2),
        .ADDR(ADDR2), .CEn(CEn2), .H18(H18_2), .H18n(H18n2), .ROM_DATA(ROM_DATA2),
        .VC(VC2), .VC_VALID(VC_VALID2), .BUSY(BUSY2)
    );

    // ROM contents, addressed by the DUT.
    always_comb begin
        ROM_DATA = 32'h0000_0000;
        case (ADDR)
            19'h00001: ROM_DATA = 32'h1234_5678;
            19'h4001C: ROM_DATA = 32'hDEAD_BEEF;
            19'h00020: ROM_DATA = 32'h0BAD_F00D;
            19'h00008: ROM_DATA = 32'h0180_0FF0;
            19'h00082: ROM_DATA = 32'hA0A0_0001;
            19'h0008A: ROM_DATA = 32'hA0A0_0002;
            19'h00092: ROM_DATA = 32'hA0A0_0003;
            default:   ROM_DATA = 32'h0000_0000;
        endcase
    end

    always_comb begin
        ROM_DATA2 = 32'h0000_0000;
        if (ADDR2 == 19'h7FFFF) begin
            ROM_DATA2 = 32'hCAFE_0001;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge M24) begin
        if (VC_VALID) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", 32'd1, 32'd0);
            end else begin
                chk("vc_data", VC, sb.pop_front());
            end
        end
    end

    always @(negedge M24) begin
        if (VC_VALID2) begin
            if (sb2.size() == 0) begin
                chk("spurious_strobe2", 32'd1, 32'd0);
            end else begin
                chk("vc_data2", VC2, sb2.pop_front());
            end
        end
    end

    // Counts falling edges until the strobe; flags CEn high before it.
    task automatic wait_strobe(output int n, output logic cen_hi);
        n = 0;
        cen_hi = 1'b0;
        do begin
            if (n > 0 && CEn) begin
                cen_hi = 1'b1;
            end
            @(negedge M24);
            n++;
        end while (!VC_VALID && n < 40);
    endtask

    task automatic fetch_one(input logic [15:0] code, input logic [2:0] row,
                             input logic flip, input logic [18:0] exp_addr,
                             input logic [31:0] exp_vc);
        int   n;
        logic ch;
        @(negedge M24);
        REQ_CODE  = code;
        REQ_ROW   = row;
        REQ_FLIPX = flip;
        REQ_VALID = 1'b1;
        @(posedge M24);
        sb.push_back(exp_vc);
        @(negedge M24);
        REQ_VALID = 1'b0;
        chk("cen_before_load", {31'd0, CEn}, 32'd1);
        @(negedge M24);
        chk("addr_load", {13'd0, ADDR}, {13'd0, exp_addr});
        chk("cen_active", {31'd0, CEn}, 32'd0);
        chk("busy_fetch", {31'd0, BUSY}, 32'd1);
        chk("h18", {30'd0, H18, H18n}, {30'd0, exp_addr[18], ~exp_addr[18]});
        wait_strobe(n, ch);
        chk("strobe_latency", n, 32'd8);
        chk("cen_held", {31'd0, ch}, 32'd0);
        @(negedge M24);
        chk("cen_release", {31'd0, CEn}, 32'd1);
        chk("strobe_one_cycle", {31'd0, VC_VALID}, 32'd0);
        chk("busy_idle", {31'd0, BUSY}, 32'd0);
        chk("vc_hold", VC, exp_vc);
    endtask

    initial begin
        logic [15:0] codes [3];
        logic [31:0] vcs [3];
        int          n;
        int          k;
        logic        ch;
        logic        cen_any;
        logic [31:0] flip_vc;

        codes = '{16'h0010, 16'h0011, 16'h0012};
        vcs   = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
`ifdef GFX_FETCH_FLIPX_EN
        flip_vc = 32'h8001_F00F;
`else
        flip_vc = 32'h0180_0FF0;
`endif

        repeat (3) @(negedge M24);
        RES = 1'b1;
        @(negedge M24);
        chk("rst_addr", {13'd0, ADDR}, 32'd0);
        chk("rst_cen", {31'd0, CEn}, 32'd1);
        chk("rst_h18", {30'd0, H18, H18n}, 32'd1);
        chk("rst_vc", VC, 32'd0);
        chk("rst_flags", {29'd0, VC_VALID, BUSY, REQ_READY}, 32'd1);

        fetch_one(16'h0000, 3'd1, 1'b0, 19'h00001, 32'h1234_5678);
        fetch_one(16'h8003, 3'd4, 1'b0, 19'h4001C, 32'hDEAD_BEEF);
        fetch_one(16'h0004, 3'd0, 1'b0, 19'h00020, 32'h0BAD_F00D);
        fetch_one(16'h0001, 3'd0, 1'b1, 19'h00008, flip_vc);
        fetch_one(16'h0001, 3'd0, 1'b0, 19'h00008, 32'h0180_0FF0);

        // Three requests offered back to back.
        @(negedge M24);
        for (int i = 0; i < 3; i++) begin
            REQ_CODE  = codes[i];
            REQ_ROW   = 3'd2;
            REQ_FLIPX = 1'b0;
            REQ_VALID = 1'b1;
            k = 0;
            while (!REQ_READY && k < 40) begin
                @(negedge M24);
                k++;
            end
            chk("accept_timeout", k < 40, 32'd1);
            @(posedge M24);
            sb.push_back(vcs[i]);
            @(negedge M24);
        end
        REQ_VALID = 1'b0;
        chk("ready_full", {31'd0, REQ_READY}, 32'd0);
        wait_strobe(n, ch);
        cen_any = ch;
        wait_strobe(n, ch);
        cen_any = cen_any | ch;
        chk("b2b_gap1", n, 32'd8);
        wait_strobe(n, ch);
        cen_any = cen_any | ch;
        chk("b2b_gap2", n, 32'd8);
        chk("b2b_cen_low", {31'd0, cen_any}, 32'd0);
        repeat (20) @(negedge M24);
        chk("b2b_drained", sb.size(), 32'd0);

        // Reset in the middle of a fetch: no strobe may follow.
        @(negedge M24);
        REQ_CODE  = 16'h8003;
        REQ_ROW   = 3'd4;
        REQ_VALID = 1'b1;
        @(posedge M24);
        @(negedge M24);
        REQ_VALID = 1'b0;
        repeat (4) @(negedge M24);
        chk("pre_rst_busy", {31'd0, BUSY}, 32'd1);
        #2 RES = 1'b0;
        #1;
        chk("mid_rst_addr", {13'd0, ADDR}, 32'd0);
        chk("mid_rst_cen", {31'd0, CEn}, 32'd1);
        chk("mid_rst_h18", {30'd0, H18, H18n}, 32'd1);
        chk("mid_rst_vc", VC, 32'd0);
        chk("mid_rst_flags", {30'd0, VC_VALID, BUSY}, 32'd0);
        repeat (3) @(negedge M24);
        RES = 1'b1;
        @(negedge M24);
        chk("post_rst_ready", {31'd0, REQ_READY}, 32'd1);
        repeat (12) @(negedge M24);
        chk("post_rst_idle", {30'd0, BUSY, CEn}, 32'd1);
        fetch_one(16'h0000, 3'd1, 1'b0, 19'h00001, 32'h1234_5678);

        // Minimum wait and address wrap on the second instance.
        @(negedge M24);
        REQ_CODE2  = 16'hFFFF;
        REQ_ROW2   = 3'd7;
        REQ_VALID2 = 1'b1;
        @(posedge M24);
        sb2.push_back(32'hCAFE_0001);
        @(negedge M24);
        REQ_VALID2 = 1'b0;
        @(negedge M24);
        chk("wrap_addr", {13'd0, ADDR2}, 32'h0007_FFFF);
        chk("wrap_h18", {29'd0, H18_2, H18n2, CEn2}, 32'd4);
        n = 0;
        do begin
            @(negedge M24);
            n++;
        end while (!VC_VALID2 && n < 40);
        chk("min_wait_latency", n, 32'd2);
        @(negedge M24);
        chk("min_wait_cen_release", {31'd0, CEn2}, 32'd1);

        repeat (5) @(negedge M24);
        chk("sb_empty", sb.size() + sb2.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gfx_rom_fetch.md
GFX_ROM_FETCH -- requirements
Module: gfx_rom_fetch

Interface
REQ-001 Parameter ROM_WAIT, default 8, cycles from an address update to the data sample; legal range 2..15.
REQ-002 M24  in  1  master clock (24 MHz); all state on the rising edge.
REQ-003 RES  in  1  reset; asynchronous, active-low.
REQ-004 REQ_VALID  in  1  tile-row fetch request present.
REQ-005 REQ_READY  out  1  request buffer can accept; combinational from the buffer count.
REQ-006 REQ_CODE  in  16  tile code; becomes ADDR[18:3].
REQ-007 REQ_ROW  in  3  tile row; becomes ADDR[2:0].
REQ-008 REQ_FLIPX  in  1  horizontal flip for this request; used only with GFX_FETCH_FLIPX_EN.
REQ-009 ADDR  out  19  GFX ROM address, registered.
REQ-010 CEn  out  1  ROM chip enable, active-low, registered.
REQ-011 H18 / H18n  out  1 each  bank output enables; H18 = ADDR[18], H18n = ~ADDR[18], combinational.
REQ-012 ROM_DATA  in  32  ROM data bus; four planes, 8 bits each, bit n of each byte = pixel n.
REQ-013 VC  out  32  captured tile-row data for k051962, registered.
REQ-014 VC_VALID  out  1  one-cycle strobe: VC updated this cycle.
REQ-015 BUSY  out  1  high while state = FETCH.

Function
REQ-016 Request buffer: 2-entry FIFO of {code, row, flipx}; push when REQ_VALID & REQ_READY at the clock edge.
REQ-017 REQ_READY = (count < 2); a request offered while full is not accepted and stays pending at the source.
REQ-018 States: IDLE, FETCH.
REQ-019 IDLE with FIFO non-empty: pop the head; ADDR <= {code,row}; CEn <= 0; cnt <= ROM_WAIT-1; go to FETCH.
REQ-020 A request pushed into an empty FIFO in IDLE is popped on the next edge: 1 cycle from acceptance to the ADDR update.
REQ-021 FETCH, cnt != 0: cnt decrements; ADDR and CEn hold.
REQ-022 FETCH, cnt == 0: VC <= ROM_DATA (processed per REQ-030/031); VC_VALID <= 1 for one cycle.
REQ-023 Same edge as REQ-022, FIFO non-empty: pop and load the next ADDR, cnt <= ROM_WAIT-1, stay in FETCH (back-to-back, one access every ROM_WAIT cycles).
REQ-024 Same edge as REQ-022, FIFO empty: CEn <= 1; ADDR holds; go to IDLE.
REQ-025 VC holds its value between strobes.
REQ-026 Push and pop on the same edge leave the count unchanged; the pushed entry queues behind the remaining entry.
REQ-027 ADDR wraps naturally: code 16'hFFFF, row 7 -> 19'h7FFFF; no carry or saturation.
REQ-028 ROM_DATA is sampled only on REQ-022 edges; it is ignored at all other times.

Reset
REQ-029 RES low asynchronously forces:
- ADDR=0, CEn=1, H18=0, H18n=1
- VC=0, VC_VALID=0, BUSY=0
- FIFO empty, state IDLE, cnt=0
A fetch in progress is aborted with no strobe. After RES rises, REQ_READY=1 and the first accepted request follows REQ-020.

Configuration
REQ-030 With GFX_FETCH_FLIPX_EN defined: when the fetched entry's flipx=1, each byte of VC is the bit-reverse of the matching ROM_DATA byte (pixel 0 <-> 7 per plane); flipx=0 passes data through unchanged.
REQ-031 Without GFX_FETCH_FLIPX_EN: REQ_FLIPX is ignored, no flip bit is stored, and VC = ROM_DATA.

Verification
REQ-032 Reset: RES low mid-FETCH -> outputs take REQ-029 values immediately; no VC_VALID; REQ_READY=1 after release.
REQ-033 Single fetch, ROM_WAIT=8: request code 16'h0000, row 1 -> ADDR=19'h00001, CEn=0 one cycle after accept; VC_VALID 8 cycles later with VC=ROM_DATA; then CEn=1.
REQ-034 Bank select: code 16'h8003, row 4 -> ADDR=19'h4001C, H18=1, H18n=0; then code 16'h0004, row 0 -> ADDR=19'h00020, H18=0.
REQ-035 Back-to-back: 3 requests offered continuously -> REQ_READY drops when 2 entries are buffered; VC_VALID strobes exactly 8 cycles apart; CEn stays 0 throughout; 3 strobes total.
REQ-036 Flip, macro defined: ROM_DATA=32'h01_80_0F_F0, flipx=1 -> VC=32'h80_01_F0_0F; macro undefined -> VC=32'h01_80_0F_F0.
REQ-037 Wrap and minimum wait: ROM_WAIT=2, code 16'hFFFF, row 7 -> ADDR=19'h7FFFF; VC_VALID 2 cycles after the ADDR update.
